// File: rtl/riscv_imm_pkg.sv
// Shared opcode constants, immediate format codes and the decoded-word record.
// imm is carried at the widest legal XLEN; each instance uses its low XLEN bits.
package riscv_imm_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int IMM_W = 64;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_NONE
    } imm_fmt_e;

    typedef struct packed {
        logic [IMM_W-1:0] imm;
        imm_fmt_e         fmt;
        logic             illegal;
    } imm_word_t;

endpackage

// File: rtl/imm_decode.sv
// Purpose: combinational opcode-to-format decode and immediate sign extension.
// Latency: zero cycles, pure combinational.
// Backpressure: none; the caller decides when the result is captured.
module imm_decode
    import riscv_imm_pkg::*;
#(
    parameter int SHIFT_BJ = 0
) (
    input  logic [31:0] instr,
    output imm_word_t   word
);

    logic sgn;

    assign sgn = instr[31];

    always_comb begin
        word         = '0;
        word.fmt     = FMT_NONE;
        word.illegal = 1'b0;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR: begin
                word.imm = {{52{sgn}}, instr[31:20]};
                word.fmt = FMT_I;
            end
            OP_STORE: begin
                word.imm = {{52{sgn}}, instr[31:25], instr[11:7]};
                word.fmt = FMT_S;
            end
            OP_BRANCH: begin
                word.imm = {{51{sgn}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                word.fmt = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                word.imm = {{32{sgn}}, instr[31:12], 12'b0};
                word.fmt = FMT_U;
            end
            OP_JAL: begin
                word.imm = {{43{sgn}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                word.fmt = FMT_J;
            end
            default: begin
                word.illegal = 1'b1;
            end
        endcase

        // Halfword-unit offsets: arithmetic shift keeps the sign for backward targets.
        if (SHIFT_BJ != 0 && (word.fmt == FMT_B || word.fmt == FMT_J)) begin
            word.imm = {word.imm[IMM_W-1], word.imm[IMM_W-1:1]};
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Purpose: registered immediate generator between instruction register and ALU B-mux.
// Latency: one cycle from accept to out_valid; one instruction per cycle sustained.
// Backpressure: 2-entry (output + skid) buffer; in_ready comes straight from the skid flop.
module imm_gen_pipe
    import riscv_imm_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int SHIFT_BJ = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output imm_fmt_e        out_fmt,
    output logic            out_illegal
);

    localparam imm_word_t WORD_RST = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0};

    imm_word_t dec_word;
    imm_word_t out_q;
    imm_word_t skid_q;
    logic      out_vld;
    logic      skid_vld;
    logic      accept;
    logic      drain;

    imm_decode #(
        .SHIFT_BJ (SHIFT_BJ)
    ) u_decode (
        .instr (in_instr),
        .word  (dec_word)
    );

    assign in_ready = !skid_vld;
    assign accept   = in_valid && !skid_vld;
    assign drain    = out_vld && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= WORD_RST;
            skid_q   <= WORD_RST;
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
        end else if (flush) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
        end else if (drain) begin
            // A full skid blocks accept, so refill comes from exactly one source.
            if (skid_vld) begin
                out_q    <= skid_q;
                out_vld  <= 1'b1;
                skid_vld <= 1'b0;
            end else if (accept) begin
                out_q   <= dec_word;
                out_vld <= 1'b1;
            end else begin
                out_vld <= 1'b0;
            end
        end else if (accept) begin
            if (!out_vld) begin
                out_q   <= dec_word;
                out_vld <= 1'b1;
            end else begin
                skid_q   <= dec_word;
                skid_vld <= 1'b1;
            end
        end
    end

    assign out_valid   = out_vld;
    assign out_imm     = out_q.imm[XLEN-1:0];
    assign out_fmt     = out_q.fmt;
    assign out_illegal = out_q.illegal;

endmodule
